// File: rtl/phase_counter.sv
// Phase counter: prescaled, saturating up/down index generator for a quarter-wave table.
// Latency: an update strobe in cycle N shows the new addr and a tick pulse in cycle N+1.
// Flow control: no backpressure; en=0 stalls the prescaler and address in place.
//
// Ports:
//   clk, rst         single rising-edge clock, asynchronous active-high reset
//   en               run enable; low holds prescaler/address and suppresses tick
//   dir              1 = count up toward MAXV, 0 = count down toward 0 (sampled on strobe)
//   div              tick period minus one (strobe every div+1 enabled cycles)
//   step             unsigned address increment per strobe (sampled on strobe)
//   addr             registered table index
//   max, zero        decoded straight from addr (addr == 2^AW-1 / addr == 0)
//   tick             registered one-cycle pulse following every address update
module phase_counter #(
    parameter int AW = 6,
    parameter int PW = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          dir,
    input  logic [PW-1:0] div,
    input  logic [SW-1:0] step,
    output logic [AW-1:0] addr,
    output logic          max,
    output logic          zero,
    output logic          tick
);

    // Arithmetic is done one bit wider than the wider operand so the
    // upward sum can never wrap before it is clamped.
    localparam int SUMW = ((AW > SW) ? AW : SW) + 1;
    localparam logic [SUMW-1:0] MAXV_W = {{(SUMW-AW){1'b0}}, {AW{1'b1}}};

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            tick_q, tick_d;
    logic            strobe;
    logic [SUMW-1:0] addr_w;
    logic [SUMW-1:0] step_w;
    logic [SUMW-1:0] up_sum;

    assign addr_w = SUMW'(addr_q);
    assign step_w = SUMW'(step);
    assign up_sum = addr_w + step_w;

    // >= rather than == so that lowering div below the running count
    // fires on the very next enabled cycle instead of waiting for a wrap.
    assign strobe = en && (pcnt_q >= div);

    always_comb begin
        pcnt_d = pcnt_q;
        addr_d = addr_q;
        tick_d = 1'b0;
        if (strobe) begin
            pcnt_d = '0;
            tick_d = 1'b1;
            if (dir) begin
                addr_d = (up_sum > MAXV_W) ? {AW{1'b1}} : up_sum[AW-1:0];
            end else begin
                // Only subtract when it cannot borrow; otherwise clamp at 0.
                addr_d = (step_w > addr_w) ? '0 : (addr_q - step_w[AW-1:0]);
            end
        end else if (en) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            addr_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            addr_q <= addr_d;
            tick_q <= tick_d;
        end
    end

    assign addr = addr_q;
    assign tick = tick_q;
    // Decoded from the register so the sequencer sees them with addr itself.
    assign max  = (addr_q == {AW{1'b1}});
    assign zero = (addr_q == '0);

endmodule
